// File: rtl/booth_div.sv
// Sequential signed restoring divider (one quotient bit per clock), start/busy/done handshake.
// Optional macro BOOTH_DIV_ZERO_DET_EN adds divide-by-zero detection and the div_by_zero output.
module booth_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef BOOTH_DIV_ZERO_DET_EN
  output logic             div_by_zero,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Two's complement negate when neg is set; -2^(WIDTH-1) maps to itself.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return cond_neg(v, v[WIDTH-1]);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef BOOTH_DIV_ZERO_DET_EN
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // dvd_q doubles as the quotient magnitude: dividend bits shift out the top, quotient bits in the bottom.
  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BOOTH_DIV_ZERO_DET_EN
    zero_d  = zero_q;
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = mag(dividend);
          dvs_d   = mag(divisor);
          prem_d  = '0;
          cnt_d   = CW'(WIDTH);
          sgnq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgnr_d  = dividend[WIDTH-1];
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef BOOTH_DIV_ZERO_DET_EN
          dbz_d  = 1'b0;
          zero_d = (divisor == '0);
          if (divisor == '0) state_d = FIX;
`endif
        end
      end
      CALC: begin
        if (!trial[WIDTH+1]) begin
          prem_d = trial[WIDTH:0];
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted[WIDTH:0];
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = cond_neg(dvd_q, sgnq_q);
        rem_d   = cond_neg(prem_q[WIDTH-1:0], sgnr_q);
`ifdef BOOTH_DIV_ZERO_DET_EN
        if (zero_q) begin
          quot_d = '0;
          rem_d  = cond_neg(dvd_q, sgnr_q);
        end
        dbz_d  = zero_q;
        zero_d = 1'b0;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BOOTH_DIV_ZERO_DET_EN
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BOOTH_DIV_ZERO_DET_EN
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef BOOTH_DIV_ZERO_DET_EN
  assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_booth_div.sv
// Directed bench for booth_div (WIDTH=4): signs, boundaries, handshake, reset abort, divide by zero.
module tb_booth_div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
`ifdef BOOTH_DIV_ZERO_DET_EN
  logic       div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  booth_div #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
`ifdef BOOTH_DIV_ZERO_DET_EN
    .div_by_zero(div_by_zero),
`endif
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues start, counts edges until done, checks busy in between and the results.
  task automatic do_op(input string tag, input logic signed [3:0] a, input logic signed [3:0] b,
                       input logic signed [3:0] exp_q, input logic signed [3:0] exp_r,
                       input int exp_lat, input bit poke);
    int n;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_first"}, busy, 1);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (busy !== 1'b1) check({tag, "_busy_mid"}, busy, 1);
      if (poke && n == 2) begin
        start = 1'b1;
        dividend = 4'sd7;
        divisor = 4'sd1;
      end
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_q"}, $signed(quotient), exp_q);
    check({tag, "_r"}, $signed(remainder), exp_r);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    #2;
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("p7_p2", 4'sd7, 4'sd2, 4'sd3, 4'sd1, 5, 1'b0);
    done_drops("p7_p2");
    do_op("n7_p2", -4'sd7, 4'sd2, -4'sd3, -4'sd1, 5, 1'b0);
    done_drops("n7_p2");
    do_op("p7_n2", 4'sd7, -4'sd2, -4'sd3, 4'sd1, 5, 1'b0);
    done_drops("p7_n2");
    do_op("n7_n2", -4'sd7, -4'sd2, 4'sd3, -4'sd1, 5, 1'b0);
    done_drops("n7_n2");

    do_op("n8_n1", -4'sd8, -4'sd1, -4'sd8, 4'sd0, 5, 1'b0);
    done_drops("n8_n1");
    do_op("n8_p1", -4'sd8, 4'sd1, -4'sd8, 4'sd0, 5, 1'b0);
    done_drops("n8_p1");
    do_op("z_p5", 4'sd0, 4'sd5, 4'sd0, 4'sd0, 5, 1'b0);
    done_drops("z_p5");
    do_op("p3_p7", 4'sd3, 4'sd7, 4'sd0, 4'sd3, 5, 1'b0);
    done_drops("p3_p7");

    // Second start lands in the done cycle of the first.
    do_op("b2b_a", 4'sd5, 4'sd2, 4'sd2, 4'sd1, 5, 1'b0);
    do_op("b2b_b", 4'sd6, 4'sd3, 4'sd2, 4'sd0, 5, 1'b0);
    done_drops("b2b_b");

    do_op("poke", 4'sd7, 4'sd2, 4'sd3, 4'sd1, 5, 1'b1);
    done_drops("poke");
    check("poke_hold_q", $signed(quotient), 3);

    // Abort two edges into CALC.
    start = 1'b1;
    dividend = 4'sd6;
    divisor = 4'sd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0) check("abort_no_done", done, 0);
    end
    check("abort_idle_busy", busy, 0);

    do_op("p5_n3", 4'sd5, -4'sd3, -4'sd1, 4'sd2, 5, 1'b0);
    done_drops("p5_n3");

`ifdef BOOTH_DIV_ZERO_DET_EN
    do_op("dz_p5", 4'sd5, 4'sd0, 4'sd0, 4'sd5, 1, 1'b0);
    check("dz_p5_flag", div_by_zero, 1);
    done_drops("dz_p5");
    do_op("dz_next", 4'sd6, 4'sd2, 4'sd3, 4'sd0, 5, 1'b0);
    check("dz_next_flag", div_by_zero, 0);
    done_drops("dz_next");
`else
    do_op("dz_p5", 4'sd5, 4'sd0, -4'sd1, 4'sd5, 5, 1'b0);
    done_drops("dz_p5");
    do_op("dz_n5", -4'sd5, 4'sd0, 4'sd1, -4'sd5, 5, 1'b0);
    done_drops("dz_n5");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
